riscv_dtcm_responder: RTL and testbench
=======================================

# riscv_dtcm_responder

Data-side memory responder for the core's `mem_d_*` bus: a tightly-coupled data RAM that accepts tagged load, store and cache-maintenance requests and returns in-order tagged acknowledges. It sits between the core's data port and a single-port word RAM. It is the target for everything the core's LSU/MMU path issues.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h80000000: byte address of RAM word 0.
- `SIZE_WORDS`, default 4096: RAM depth in 32-bit words; must be a power of 2.
- `WAIT_STATES`, default 0: extra cycles inserted before each ack; range 0–15.

Ports (clock and reset first):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `mem_d_addr_i` in 32: byte address.
- `mem_d_data_wr_i` in 32: store data.
- `mem_d_rd_i` in 1: load request.
- `mem_d_wr_i` in 4: byte-lane store strobes.
- `mem_d_cacheable_i` in 1: ignored.
- `mem_d_req_tag_i` in 11: request tag.
- `mem_d_invalidate_i`, `mem_d_writeback_i`, `mem_d_flush_i` in 1 each: maintenance requests.
- `mem_d_accept_o` out 1: request taken this cycle.
- `mem_d_ack_o` out 1: one-cycle response strobe.
- `mem_d_error_o` out 1: response is an error; valid with ack.
- `mem_d_data_rd_o` out 32: load data; valid with ack.
- `mem_d_resp_tag_o` out 11: echoed tag; valid with ack.

## Operation
- **Request:** a request is any of `rd`, `|wr`, `invalidate`, `writeback`, `flush` high. Handshake completes when a request is present and `mem_d_accept_o`=1 in the same cycle.
- **Accept:**
  - `mem_d_accept_o` = (queue count < 2) and not `rst_i`.
  - Combinational from registered count only. It never depends on request inputs.
- **Queue:** 2-entry FIFO holding {addr word index, wdata, wr strobes, rd, maint, tag, err}. Responses are strictly in order.
- **Service FSM:**
  - `S_IDLE`: queue empty → stay. Non-empty → load `wait_cnt` with `WAIT_STATES`, go to `S_WAIT`.
  - `S_WAIT`: `wait_cnt`≠0 → decrement. `wait_cnt`=0 → perform access, go to `S_RESP`.
  - `S_RESP`: ack registered high this cycle and head popped. Then:
    - queue still non-empty → reload `wait_cnt`, go to `S_WAIT`;
    - otherwise → `S_IDLE`.
- **Access:**
  - **Store:** the lanes with `wr[i]`=1 write byte i. Other lanes are unchanged.
  - **Load:** full word returned. `addr[1:0]` is ignored.
  - **Maintenance-only request:** no RAM effect; data 0.
- **Errors** (ack with `error`=1, no RAM write, data 0):
  - `rd` and `|wr` both set;
  - out-of-range address, when range checking is enabled (see Configuration).
- **Push and pop in the same edge:** permitted. Count is unchanged.
- **Reset:**
  - `mem_d_ack_o`=0, `mem_d_error_o`=0, `mem_d_data_rd_o`=0, `mem_d_resp_tag_o`=0.
  - Queue empty, FSM `S_IDLE`, `wait_cnt`=0.
  - `mem_d_accept_o`=0 while `rst_i` is high.
  - RAM contents are not reset.
- **Reset mid-operation:** queued and in-flight requests are discarded with no ack. A store that has not yet reached its access point does not write.

## Timing
- **Handshake:** in cycle T.
- **Ack:** in cycle T+2+`WAIT_STATES` when the queue ahead of the request is empty.
- **Ack width:** exactly 1 cycle. `data_rd`, `error` and `resp_tag` are held until the next ack.
- **Throughput:**
  - `WAIT_STATES`=0: one request per cycle sustained, accept stays high.
  - `WAIT_STATES`=N: one request per 1+N cycles.
- **Back-pressure:** none on the response side. The core must always sink acks.
- **Store visibility:** a store is visible to a load accepted at or after the store's ack cycle. In-order servicing also guarantees this for back-to-back store→load to the same word.

## Configuration
- Macro: `DTCM_RANGE_CHECK_EN`.
- **Defined:**
  - Address outside [`ADDR_BASE`, `ADDR_BASE`+4·`SIZE_WORDS`) is flagged at enqueue.
  - It is acked with `error`=1 and has no RAM effect.
- **Undefined:**
  - No check. Word index = `addr[log2(SIZE_WORDS)+1:2]`, so out-of-range addresses alias modulo the RAM size.
  - `error` is raised only for the rd+wr conflict.

## Structure
- **Package `riscv_dtcm_pkg`:**
  - FSM state enum {`S_IDLE`, `S_WAIT`, `S_RESP`};
  - queue entry struct;
  - `DTCM_TAG_W`=11;
  - `DTCM_QUEUE_DEPTH`=2.
- **Sub-module `riscv_dtcm_req_fifo`:** 2-entry synchronous FIFO with push/pop/count. It is reset asynchronously by `rst_i`.
- The RAM is an inferred register array inside the top module, with write-first byte enables.

## Test plan
- **Store then load:** store 32'hDEADBEEF, `wr`=4'hF, tag 5 at 32'h80000010, then load the same address with tag 6.
  - Two acks with tags 5 then 6.
  - Load data 32'hDEADBEEF, `error`=0.
- **Byte lanes:**
  - Preload the word with 32'h11223344.
  - Store 32'hAABBCCDD with `wr`=4'b0101.
  - Load returns 32'h11BB33DD.
- **Back-to-back loads, `WAIT_STATES`=0:** 4 consecutive loads with tags 1–4.
  - Accept high every cycle.
  - Acks in consecutive cycles T+2..T+5 with tags 1–4 in order.
- **`WAIT_STATES`=3:** 3 requests issued back-to-back.
  - First ack at T+5, then spacing of 4 cycles.
  - Accept drops while count=2.
- **Errors:**
  - With `DTCM_RANGE_CHECK_EN`: store to 32'h7FFFFFFC → ack `error`=1, RAM unchanged.
  - Without `DTCM_RANGE_CHECK_EN`: the same store writes word index `SIZE_WORDS`-1.
  - `rd`=1 with `wr`=4'hF → `error`=1 in both builds.
- **Reset mid-operation:** assert `rst_i` one cycle after accepting a store to 32'h80000000.
  - No ack is produced.
  - Accept is 0 while in reset.
  - A later load of that address returns the pre-store value.

Source files
------------

// File: rtl/riscv_dtcm_pkg.sv
// riscv_dtcm_pkg: shared types and constants for the data-side TCM responder.
// Holds the service FSM states, the request queue entry layout, tag width and queue depth.
package riscv_dtcm_pkg;

    localparam int DTCM_TAG_W       = 11;
    localparam int DTCM_QUEUE_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } dtcm_state_t;

    // The word field keeps the full byte address >> 2 so the top can derive
    // either the aliased index or the base-relative index from it.
    typedef struct packed {
        logic [29:0]           word;
        logic [31:0]           wdata;
        logic [3:0]            wr;
        logic                  rd;
        logic                  maint;
        logic [DTCM_TAG_W-1:0] tag;
        logic                  err;
    } dtcm_entry_t;

endpackage

// File: rtl/riscv_dtcm_req_fifo.sv
// riscv_dtcm_req_fifo: 2-entry synchronous request queue for the data TCM responder.
// Ports: clk_i, rst_i (async, active-high), push/din, pop, head (oldest entry), count.
module riscv_dtcm_req_fifo
    import riscv_dtcm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  logic        pop,
    input  dtcm_entry_t din,
    output dtcm_entry_t head,
    output logic [1:0]  count
);

    dtcm_entry_t slot [DTCM_QUEUE_DEPTH];
    logic        wptr;
    logic        rptr;

    assign head = slot[rptr];

    // Payload storage carries no reset; only the pointers and count matter.
    always_ff @(posedge clk_i) begin
        if (push) begin
            slot[wptr] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_dtcm_responder.sv
// riscv_dtcm_responder: tightly-coupled data RAM serving the core's mem_d_* bus
// with tagged, in-order acks. Optional address range check: DTCM_RANGE_CHECK_EN.
// Ports: clk_i, rst_i (async, active-high); request addr/data_wr/rd/wr/cacheable/
// req_tag/invalidate/writeback/flush; response accept/ack/error/data_rd/resp_tag.
module riscv_dtcm_responder
    import riscv_dtcm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          SIZE_WORDS  = 4096,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           mem_d_addr_i,
    input  logic [31:0]           mem_d_data_wr_i,
    input  logic                  mem_d_rd_i,
    input  logic [3:0]            mem_d_wr_i,
    input  logic                  mem_d_cacheable_i,
    input  logic [DTCM_TAG_W-1:0] mem_d_req_tag_i,
    input  logic                  mem_d_invalidate_i,
    input  logic                  mem_d_writeback_i,
    input  logic                  mem_d_flush_i,
    output logic                  mem_d_accept_o,
    output logic                  mem_d_ack_o,
    output logic                  mem_d_error_o,
    output logic [31:0]           mem_d_data_rd_o,
    output logic [DTCM_TAG_W-1:0] mem_d_resp_tag_o
);

    localparam int AW = $clog2(SIZE_WORDS);
    // The first wait cycle overlaps the cycle that notices the queued entry.
    localparam logic [3:0] WS_RELOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0]   ram [SIZE_WORDS];
    dtcm_state_t   state;
    logic [3:0]    wait_cnt;
    logic [1:0]    q_count;
    dtcm_entry_t   q_head;
    dtcm_entry_t   q_din;
    logic          req;
    logic          push;
    logic          perform;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic          unused;

    assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
               | mem_d_writeback_i | mem_d_flush_i;

    assign mem_d_accept_o = (q_count < 2'(DTCM_QUEUE_DEPTH)) && !rst_i;
    assign push = req && mem_d_accept_o;

`ifdef DTCM_RANGE_CHECK_EN
    localparam logic [31:0] SPAN = 32'(4 * SIZE_WORDS);
    logic [31:0] offset;
    assign offset   = mem_d_addr_i - ADDR_BASE;
    assign addr_err = offset >= SPAN;
    assign idx      = AW'(q_head.word - ADDR_BASE[31:2]);
    assign unused   = ^{mem_d_cacheable_i, mem_d_addr_i[1:0], q_head};
`else
    assign addr_err = 1'b0;
    assign idx      = q_head.word[AW-1:0];
    assign unused   = ^{mem_d_cacheable_i, mem_d_addr_i[1:0], q_head, ADDR_BASE};
`endif

    always_comb begin
        q_din       = '0;
        q_din.word  = mem_d_addr_i[31:2];
        q_din.wdata = mem_d_data_wr_i;
        q_din.wr    = mem_d_wr_i;
        q_din.rd    = mem_d_rd_i;
        q_din.maint = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        q_din.tag   = mem_d_req_tag_i;
        q_din.err   = (mem_d_rd_i && (|mem_d_wr_i)) || addr_err;
    end

    riscv_dtcm_req_fifo u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (perform),
        .din   (q_din),
        .head  (q_head),
        .count (q_count)
    );

    // Access point: the head is serviced and popped on this edge.
    // With no wait states it happens straight from idle/resp.
    assign perform = (q_count != 2'd0) &&
                     ((state == S_WAIT) ? (wait_cnt == 4'd0)
                                        : (WAIT_STATES == 0));

    assign rdata = (q_head.rd && !q_head.err) ? ram[idx] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (perform && !q_head.err && !q_head.rd) begin
            for (int i = 0; i < 4; i++) begin
                if (q_head.wr[i]) begin
                    ram[idx][8*i +: 8] <= q_head.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            wait_cnt         <= 4'd0;
            mem_d_ack_o      <= 1'b0;
            mem_d_error_o    <= 1'b0;
            mem_d_data_rd_o  <= 32'd0;
            mem_d_resp_tag_o <= '0;
        end else begin
            mem_d_ack_o <= 1'b0;
            if (perform) begin
                mem_d_ack_o      <= 1'b1;
                mem_d_error_o    <= q_head.err;
                mem_d_data_rd_o  <= rdata;
                mem_d_resp_tag_o <= q_head.tag;
            end
            unique case (state)
                S_IDLE, S_RESP: begin
                    if (q_count == 2'd0) begin
                        state <= S_IDLE;
                    end else if (WAIT_STATES == 0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= WS_RELOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dtcm_responder.sv
// tb_riscv_dtcm_responder: self-checking bench for the data TCM responder.
// Drives a WAIT_STATES=0 and a WAIT_STATES=3 instance; honours DTCM_RANGE_CHECK_EN.
`timescale 1ns/1ps
module tb_riscv_dtcm_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          SIZE = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cach;
    logic [31:0] addr, wdata;
    logic        rd, inv, wb, fl;
    logic [3:0]  wr;
    logic [10:0] tag;
    logic        accept, ack, err;
    logic [31:0] rdata;
    logic [10:0] rtag;

    logic [31:0] addr3, wdata3;
    logic        rd3, inv3, wb3, fl3;
    logic [3:0]  wr3;
    logic [10:0] tag3;
    logic        accept3, ack3, err3;
    logic [31:0] rdata3;
    logic [10:0] rtag3;

    riscv_dtcm_responder #(.ADDR_BASE(BASE), .SIZE_WORDS(SIZE), .WAIT_STATES(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata),
        .mem_d_rd_i(rd), .mem_d_wr_i(wr), .mem_d_cacheable_i(cach),
        .mem_d_req_tag_i(tag), .mem_d_invalidate_i(inv),
        .mem_d_writeback_i(wb), .mem_d_flush_i(fl),
        .mem_d_accept_o(accept), .mem_d_ack_o(ack), .mem_d_error_o(err),
        .mem_d_data_rd_o(rdata), .mem_d_resp_tag_o(rtag)
    );

    riscv_dtcm_responder #(.ADDR_BASE(BASE), .SIZE_WORDS(SIZE), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .mem_d_addr_i(addr3), .mem_d_data_wr_i(wdata3),
        .mem_d_rd_i(rd3), .mem_d_wr_i(wr3), .mem_d_cacheable_i(cach),
        .mem_d_req_tag_i(tag3), .mem_d_invalidate_i(inv3),
        .mem_d_writeback_i(wb3), .mem_d_flush_i(fl3),
        .mem_d_accept_o(accept3), .mem_d_ack_o(ack3), .mem_d_error_o(err3),
        .mem_d_data_rd_o(rdata3), .mem_d_resp_tag_o(rtag3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [10:0] tag;
        logic [31:0] data;
        logic        err;
    } ack_t;

    ack_t log0[$];
    ack_t log3[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Ack recorder: stamps every response with the cycle it was seen in.
    always @(negedge clk) begin
        if (ack === 1'b1) log0.push_back('{cyc, rtag, rdata, err});
        if (ack3 === 1'b1) log3.push_back('{cyc, rtag3, rdata3, err3});
    end

    // Reference memory: word index -> contents, updated in acceptance order.
    logic [31:0] mdl [int];

    function automatic logic is_err(logic [31:0] a, logic r, logic [3:0] w);
        logic e;
        e = r && (w != 4'd0);
`ifdef DTCM_RANGE_CHECK_EN
        if (a < BASE || a >= BASE + 32'(4 * SIZE)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int widx(logic [31:0] a);
`ifdef DTCM_RANGE_CHECK_EN
        return int'((a - BASE) / 4);
`else
        return int'((a / 4) % SIZE);
`endif
    endfunction

    function automatic logic [31:0] model_access(logic [31:0] a, logic [31:0] d,
                                                 logic r, logic [3:0] w);
        int          i;
        logic [31:0] v;
        if (is_err(a, r, w)) return 32'd0;
        i = widx(a);
        v = mdl.exists(i) ? mdl[i] : 32'hxxxx_xxxx;
        if (w != 4'd0) begin
            for (int b = 0; b < 4; b++)
                if (w[b]) v[8*b +: 8] = d[8*b +: 8];
            mdl[i] = v;
        end
        return r ? v : 32'd0;
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic [3:0] w, input logic [10:0] t, input logic m);
        addr = a; wdata = d; rd = r; wr = w; tag = t;
        inv = m; wb = 1'b0; fl = 1'b0;
    endtask

    task automatic put_idle();
        put(32'd0, 32'd0, 1'b0, 4'd0, 11'd0, 1'b0);
    endtask

    task automatic put3(input logic [31:0] a, input logic [31:0] d, input logic r,
                        input logic [3:0] w, input logic [10:0] t);
        addr3 = a; wdata3 = d; rd3 = r; wr3 = w; tag3 = t;
        inv3 = 1'b0; wb3 = 1'b0; fl3 = 1'b0;
    endtask

    task automatic wait_acks(input bit on3, input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if ((on3 ? log3.size() : log0.size()) >= n) break;
            @(posedge clk);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        put_idle();
        put3(32'd0, 32'd0, 1'b0, 4'd0, 11'd0);
        repeat (3) @(negedge clk);
        n_cmp++; if (accept !== 1'b0) begin n_bad++; $display("FAIL reset_accept: got %b want 0", accept); end
        n_cmp++; if (accept3 !== 1'b0) begin n_bad++; $display("FAIL reset_accept3: got %b want 0", accept3); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rdata); end
        n_cmp++; if (rtag !== 11'd0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", rtag); end
        rst = 1'b0;
        #1;
        n_cmp++; if (accept !== 1'b1) begin n_bad++; $display("FAIL post_reset_accept: got %b want 1", accept); end
    endtask

    task automatic test_store_load();
        int c0;
        log0.delete();
        @(negedge clk);
        put(BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 4'hF, 11'd5, 1'b0);
        c0 = cyc;
        @(negedge clk);
        put(BASE + 32'h10, 32'd0, 1'b1, 4'h0, 11'd6, 1'b0);
        @(negedge clk);
        put_idle();
        wait_acks(1'b0, 2, 20);
        n_cmp++; if (log0.size() != 2) begin n_bad++; $display("FAIL sl_count: got %0d want 2", log0.size()); end
        if (log0.size() == 2) begin
            n_cmp++; if (log0[0].tag !== 11'd5) begin n_bad++; $display("FAIL sl_tag0: got %0d want 5", log0[0].tag); end
            n_cmp++; if (log0[0].cyc != c0 + 2) begin n_bad++; $display("FAIL sl_lat0: got %0d want %0d", log0[0].cyc, c0 + 2); end
            n_cmp++; if (log0[1].tag !== 11'd6) begin n_bad++; $display("FAIL sl_tag1: got %0d want 6", log0[1].tag); end
            n_cmp++; if (log0[1].data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sl_data: got %h want deadbeef", log0[1].data); end
            n_cmp++; if (log0[1].err !== 1'b0) begin n_bad++; $display("FAIL sl_err: got %b want 0", log0[1].err); end
            n_cmp++; if (log0[1].cyc != c0 + 3) begin n_bad++; $display("FAIL sl_lat1: got %0d want %0d", log0[1].cyc, c0 + 3); end
        end
    endtask

    task automatic test_byte_lanes();
        log0.delete();
        @(negedge clk); put(BASE + 32'h20, 32'h1122_3344, 1'b0, 4'hF, 11'd10, 1'b0);
        @(negedge clk); put(BASE + 32'h20, 32'hAABB_CCDD, 1'b0, 4'b0101, 11'd11, 1'b0);
        @(negedge clk); put(BASE + 32'h22, 32'd0, 1'b1, 4'h0, 11'd12, 1'b0);
        @(negedge clk); put(BASE + 32'h20, 32'hFFFF_FFFF, 1'b0, 4'h0, 11'd13, 1'b1);
        @(negedge clk); put_idle();
        wait_acks(1'b0, 4, 20);
        n_cmp++; if (log0.size() != 4) begin n_bad++; $display("FAIL bl_count: got %0d want 4", log0.size()); end
        if (log0.size() == 4) begin
            n_cmp++; if (log0[2].data !== 32'h11BB_33DD) begin n_bad++; $display("FAIL bl_data: got %h want 11bb33dd", log0[2].data); end
            n_cmp++; if (log0[2].tag !== 11'd12) begin n_bad++; $display("FAIL bl_tag: got %0d want 12", log0[2].tag); end
            n_cmp++; if (log0[3].data !== 32'd0) begin n_bad++; $display("FAIL maint_data: got %h want 0", log0[3].data); end
            n_cmp++; if (log0[3].err !== 1'b0) begin n_bad++; $display("FAIL maint_err: got %b want 0", log0[3].err); end
            n_cmp++; if (log0[3].tag !== 11'd13) begin n_bad++; $display("FAIL maint_tag: got %0d want 13", log0[3].tag); end
        end
    endtask

    task automatic test_back_to_back();
        int          c0;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hDEAD_BEEF; exp_d[1] = 32'h11BB_33DD;
        exp_d[2] = 32'hDEAD_BEEF; exp_d[3] = 32'h11BB_33DD;
        log0.delete();
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put(BASE + ((i % 2 == 0) ? 32'h10 : 32'h20), 32'd0, 1'b1, 4'h0, 11'(i + 1), 1'b0);
            if (i == 0) c0 = cyc;
            n_cmp++; if (accept !== 1'b1) begin n_bad++; $display("FAIL b2b_accept%0d: got %b want 1", i, accept); end
        end
        @(negedge clk); put_idle();
        wait_acks(1'b0, 4, 20);
        n_cmp++; if (log0.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", log0.size()); end
        for (int i = 0; i < log0.size() && i < 4; i++) begin
            n_cmp++; if (log0[i].cyc != c0 + 2 + i) begin n_bad++; $display("FAIL b2b_lat%0d: got %0d want %0d", i, log0[i].cyc, c0 + 2 + i); end
            n_cmp++; if (log0[i].tag !== 11'(i + 1)) begin n_bad++; $display("FAIL b2b_tag%0d: got %0d want %0d", i, log0[i].tag, i + 1); end
            n_cmp++; if (log0[i].data !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, log0[i].data, exp_d[i]); end
        end
    endtask

    task automatic test_wait_states();
        int   hs [3];
        int   n;
        int   c_start;
        logic acc_at2;
        log3.delete();
        n = 0;
        acc_at2 = 1'bx;
        c_start = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (n == 0) put3(BASE + 32'h40, 32'h1234_5678, 1'b0, 4'hF, 11'd21);
            else if (n == 1) put3(BASE + 32'h40, 32'hAA00_0000, 1'b0, 4'b1000, 11'd22);
            else put3(BASE + 32'h40, 32'd0, 1'b1, 4'h0, 11'd23);
            if (k == 0) c_start = cyc;
            if (cyc == c_start + 2) acc_at2 = accept3;
            if (accept3 === 1'b1) begin
                hs[n] = cyc;
                n++;
            end
        end
        @(negedge clk); put3(32'd0, 32'd0, 1'b0, 4'd0, 11'd0);
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL ws_accepts: got %0d want 3", n); end
        n_cmp++; if (acc_at2 !== 1'b0) begin n_bad++; $display("FAIL ws_accept_full: got %b want 0", acc_at2); end
        if (n == 3) begin
            n_cmp++; if (hs[1] != hs[0] + 1) begin n_bad++; $display("FAIL ws_hs1: got %0d want %0d", hs[1], hs[0] + 1); end
            n_cmp++; if (hs[2] != hs[0] + 5) begin n_bad++; $display("FAIL ws_hs2: got %0d want %0d", hs[2], hs[0] + 5); end
        end
        wait_acks(1'b1, 3, 60);
        n_cmp++; if (log3.size() != 3) begin n_bad++; $display("FAIL ws_count: got %0d want 3", log3.size()); end
        if (log3.size() == 3 && n == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (log3[i].cyc != hs[0] + 5 + 4 * i) begin n_bad++; $display("FAIL ws_lat%0d: got %0d want %0d", i, log3[i].cyc, hs[0] + 5 + 4 * i); end
                n_cmp++; if (log3[i].tag !== 11'(21 + i)) begin n_bad++; $display("FAIL ws_tag%0d: got %0d want %0d", i, log3[i].tag, 21 + i); end
            end
            n_cmp++; if (log3[2].data !== 32'hAA34_5678) begin n_bad++; $display("FAIL ws_data: got %h want aa345678", log3[2].data); end
        end
    endtask

    task automatic test_errors();
        logic        exp_oor_err;
        logic [31:0] exp_last;
`ifdef DTCM_RANGE_CHECK_EN
        exp_oor_err = 1'b1; exp_last = 32'h0BAD_BEEF;
`else
        exp_oor_err = 1'b0; exp_last = 32'hCAFE_F00D;
`endif
        log0.delete();
        @(negedge clk); put(BASE + 32'(4 * (SIZE - 1)), 32'h0BAD_BEEF, 1'b0, 4'hF, 11'd30, 1'b0);
        @(negedge clk); put(32'h7FFF_FFFC, 32'hCAFE_F00D, 1'b0, 4'hF, 11'd31, 1'b0);
        @(negedge clk); put(BASE + 32'h10, 32'h5555_5555, 1'b1, 4'hF, 11'd32, 1'b0);
        @(negedge clk); put(BASE + 32'(4 * (SIZE - 1)), 32'd0, 1'b1, 4'h0, 11'd33, 1'b0);
        @(negedge clk); put(BASE + 32'h10, 32'd0, 1'b1, 4'h0, 11'd34, 1'b0);
        @(negedge clk); put_idle();
        wait_acks(1'b0, 5, 20);
        n_cmp++; if (log0.size() != 5) begin n_bad++; $display("FAIL err_count: got %0d want 5", log0.size()); end
        if (log0.size() == 5) begin
            n_cmp++; if (log0[1].err !== exp_oor_err) begin n_bad++; $display("FAIL err_oor: got %b want %b", log0[1].err, exp_oor_err); end
            n_cmp++; if (log0[2].err !== 1'b1) begin n_bad++; $display("FAIL err_conflict: got %b want 1", log0[2].err); end
            n_cmp++; if (log0[2].data !== 32'd0) begin n_bad++; $display("FAIL err_conflict_data: got %h want 0", log0[2].data); end
            n_cmp++; if (log0[3].data !== exp_last) begin n_bad++; $display("FAIL err_lastword: got %h want %h", log0[3].data, exp_last); end
            n_cmp++; if (log0[3].err !== 1'b0) begin n_bad++; $display("FAIL err_lastword_err: got %b want 0", log0[3].err); end
            n_cmp++; if (log0[4].data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL err_nowrite: got %h want deadbeef", log0[4].data); end
        end
    endtask

    task automatic test_reset_mid();
        log0.delete();
        @(negedge clk); put(BASE, 32'h0102_0304, 1'b0, 4'hF, 11'd40, 1'b0);
        @(negedge clk); put_idle();
        wait_acks(1'b0, 1, 20);
        log0.delete();
        @(negedge clk); put(BASE, 32'hFFFF_FFFF, 1'b0, 4'hF, 11'd41, 1'b0);
        n_cmp++; if (accept !== 1'b1) begin n_bad++; $display("FAIL rm_accept: got %b want 1", accept); end
        @(negedge clk); put_idle(); rst = 1'b1;
        #1;
        n_cmp++; if (accept !== 1'b0) begin n_bad++; $display("FAIL rm_accept_rst: got %b want 0", accept); end
        @(negedge clk);
        n_cmp++; if (accept !== 1'b0) begin n_bad++; $display("FAIL rm_accept_rst2: got %b want 0", accept); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (log0.size() != 0) begin n_bad++; $display("FAIL rm_noack: got %0d acks want 0", log0.size()); end
        log0.delete();
        @(negedge clk); put(BASE, 32'd0, 1'b1, 4'h0, 11'd42, 1'b0);
        @(negedge clk); put_idle();
        wait_acks(1'b0, 1, 20);
        n_cmp++; if (log0.size() != 1) begin n_bad++; $display("FAIL rm_load_count: got %0d want 1", log0.size()); end
        if (log0.size() == 1) begin
            n_cmp++; if (log0[0].data !== 32'h0102_0304) begin n_bad++; $display("FAIL rm_data: got %h want 01020304", log0[0].data); end
        end
    endtask

    task automatic test_random();
        ack_t        expq[$];
        logic [31:0] a, d, x;
        logic        r, m;
        logic [3:0]  w;
        logic [10:0] t;
        int          kind;
        mdl.delete();
        log0.delete();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            d = $urandom();
            t = 11'($urandom());
            r = 1'b0; w = 4'h0; m = 1'b0;
            kind = (k < 8) ? 5 : int'($urandom_range(0, 9));
            if (k < 8) a = BASE + 32'h100 + 32'(4 * k);
            case (kind)
                3, 4: r = 1'b1;
                5, 6: w = (k < 8) ? 4'hF : 4'($urandom_range(1, 15));
                7:    m = 1'b1;
                8:    begin r = 1'b1; w = 4'hF; end
                9:    begin r = 1'b1; a = a + 32'(4 * SIZE); end
                default: ;
            endcase
            cach = 1'($urandom());
            put(a, d, r, w, t, m);
            if (m) begin
                inv = 1'b0;
                case ($urandom_range(0, 2))
                    0: inv = 1'b1;
                    1: wb = 1'b1;
                    default: fl = 1'b1;
                endcase
            end
            n_cmp++; if (accept !== 1'b1) begin n_bad++; $display("FAIL rnd_accept: got %b want 1 at cycle %0d", accept, cyc); end
            if ((r || w != 4'd0 || m) && accept === 1'b1) begin
                x = model_access(a, d, r, w);
                expq.push_back('{cyc + 2, t, x, is_err(a, r, w)});
            end
        end
        @(negedge clk); put_idle();
        wait_acks(1'b0, expq.size(), 20);
        n_cmp++; if (log0.size() != expq.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", log0.size(), expq.size()); end
        for (int i = 0; i < log0.size() && i < expq.size(); i++) begin
            n_cmp++; if (log0[i].cyc != expq[i].cyc) begin n_bad++; $display("FAIL rnd_lat%0d: got %0d want %0d", i, log0[i].cyc, expq[i].cyc); end
            n_cmp++; if (log0[i].tag !== expq[i].tag) begin n_bad++; $display("FAIL rnd_tag%0d: got %h want %h", i, log0[i].tag, expq[i].tag); end
            n_cmp++; if (log0[i].data !== expq[i].data) begin n_bad++; $display("FAIL rnd_data%0d: got %h want %h", i, log0[i].data, expq[i].data); end
            n_cmp++; if (log0[i].err !== expq[i].err) begin n_bad++; $display("FAIL rnd_err%0d: got %b want %b", i, log0[i].err, expq[i].err); end
        end
    endtask

    initial begin
        cach = 1'b0;
        rst  = 1'b1;
        put_idle();
        put3(32'd0, 32'd0, 1'b0, 4'd0, 11'd0);
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
